// File: rtl/io_2to1_pkg.sv
// Shared widths, FSM state encodings and the redundancy fold for the 2-to-1 merge harness.
package io_2to1_pkg;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;

    typedef enum logic [2:0] {
        SRC_IDLE,
        SRC_DST,
        SRC_DAT,
        SRC_RED,
        SRC_REQ
    } src_state_e;

    typedef enum logic [2:0] {
        SNK_WAIT,
        SNK_LATCH,
        SNK_CALC,
        SNK_CHECK,
        SNK_ACK
    } snk_state_e;

    // XOR-folds {src,dst,dat} onto rsz bits: bit p of the concatenation lands on bit p mod rsz.
    function automatic logic [31:0] calc_redun(input logic [31:0] src, input logic [31:0] dst,
                                               input logic [31:0] dat, input int asz,
                                               input int dsz, input int rsz);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < dsz) r[5'(i % rsz)]               ^= dat[i];
            if (i < asz) r[5'((i + dsz) % rsz)]       ^= dst[i];
            if (i < asz) r[5'((i + dsz + asz) % rsz)] ^= src[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/io_2to1_src.sv
// One message source: stamps src, walks dst through [MIN,MAX], sends a 4-bit counter as data.
// Four-phase req/ack; fields are stable whenever req_o is high.
module io_2to1_src
    import io_2to1_pkg::*;
#(
    parameter int SRC_ADDR = 9,
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 1,
    parameter int ASZ      = NS_ADDRESS_SIZE,
    parameter int DSZ      = NS_DATA_SIZE,
    parameter int RSZ      = NS_REDUN_SIZE
) (
    input  logic           clk_i,
    input  logic           reset_i,
    output logic [ASZ-1:0] src_o,
    output logic [ASZ-1:0] dst_o,
    output logic [DSZ-1:0] dat_o,
    output logic [RSZ-1:0] red_o,
    output logic           req_o,
    input  logic           ack_i
);

    src_state_e     state_q;
    logic [ASZ-1:0] src_q;
    logic [ASZ-1:0] dst_q;
    logic [ASZ-1:0] dst_d;
    logic [DSZ-1:0] dat_q;
    logic [RSZ-1:0] red_q;
    logic [3:0]     cnt_q;
    logic           req_q;

    always_comb begin
        dst_d = (dst_q >= ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR) : dst_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= SRC_IDLE;
            src_q   <= ASZ'(SRC_ADDR);
            dst_q   <= ASZ'(MIN_ADDR);
            dat_q   <= '0;
            red_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                // A held-high ack from the previous handshake keeps the source parked here.
                SRC_IDLE: if (!req_q && !ack_i) state_q <= SRC_DST;
                SRC_DST: begin
                    dst_q   <= dst_d;
                    state_q <= SRC_DAT;
                end
                SRC_DAT: begin
                    dat_q   <= DSZ'(cnt_q);
                    cnt_q   <= cnt_q + 4'd1;
                    state_q <= SRC_RED;
                end
                SRC_RED: begin
                    red_q   <= RSZ'(calc_redun(32'(src_q), 32'(dst_q), 32'(dat_q), ASZ, DSZ, RSZ));
                    req_q   <= 1'b1;
                    state_q <= SRC_REQ;
                end
                SRC_REQ: begin
                    if (ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= SRC_IDLE;
                    end
                end
                default: state_q <= SRC_IDLE;
            endcase
        end
    end

    assign src_o = src_q;
    assign dst_o = dst_q;
    assign dat_o = dat_q;
    assign red_o = red_q;
    assign req_o = req_q;

endmodule

// File: rtl/io_2to1.sv
// Harness around a 2-to-1 merge node: two sources drive the DUT, an inline sink checks its output.
// Sink acks 4 cycles after seeing req; errors are sticky on dbg_leds until reset.
module io_2to1
    import io_2to1_pkg::*;
#(
    parameter int MIN_ADDR  = 1,
    parameter int MAX_ADDR  = 1,
    parameter int SRC0_ADDR = 9,
    parameter int SRC1_ADDR = 10,
    parameter int ASZ       = NS_ADDRESS_SIZE,
    parameter int DSZ       = NS_DATA_SIZE,
    parameter int RSZ       = NS_REDUN_SIZE
) (
    input  logic           clk_i,
    input  logic           reset_i,
    output logic [ASZ-1:0] o0_src_o,
    output logic [ASZ-1:0] o0_dst_o,
    output logic [DSZ-1:0] o0_dat_o,
    output logic [RSZ-1:0] o0_red_o,
    output logic           o0_req_o,
    input  logic           o0_ack_i,
    output logic [ASZ-1:0] o1_src_o,
    output logic [ASZ-1:0] o1_dst_o,
    output logic [DSZ-1:0] o1_dat_o,
    output logic [RSZ-1:0] o1_red_o,
    output logic           o1_req_o,
    input  logic           o1_ack_i,
    input  logic [ASZ-1:0] i0_src_i,
    input  logic [ASZ-1:0] i0_dst_i,
    input  logic [DSZ-1:0] i0_dat_i,
    input  logic [RSZ-1:0] i0_red_i,
    input  logic           i0_req_i,
    output logic           i0_ack_o,
    output logic [3:0]     dbg_leds_o,
    output logic [3:0]     dbg_disp0_o,
    output logic [3:0]     dbg_disp1_o
);

    io_2to1_src #(
        .SRC_ADDR(SRC0_ADDR), .MIN_ADDR(MIN_ADDR), .MAX_ADDR(MAX_ADDR),
        .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)
    ) u_src0 (
        .clk_i(clk_i), .reset_i(reset_i),
        .src_o(o0_src_o), .dst_o(o0_dst_o), .dat_o(o0_dat_o), .red_o(o0_red_o),
        .req_o(o0_req_o), .ack_i(o0_ack_i)
    );

    io_2to1_src #(
        .SRC_ADDR(SRC1_ADDR), .MIN_ADDR(MIN_ADDR), .MAX_ADDR(MAX_ADDR),
        .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)
    ) u_src1 (
        .clk_i(clk_i), .reset_i(reset_i),
        .src_o(o1_src_o), .dst_o(o1_dst_o), .dat_o(o1_dat_o), .red_o(o1_red_o),
        .req_o(o1_req_o), .ack_i(o1_ack_i)
    );

    snk_state_e     snk_state_q;
    logic           ack_q;
    logic [ASZ-1:0] l_src_q;
    logic [ASZ-1:0] l_dst_q;
    logic [DSZ-1:0] l_dat_q;
    logic [RSZ-1:0] l_red_q;
    logic [RSZ-1:0] calc_red_q;
    logic           seen0_q, seen1_q;
    logic [3:0]     last0_q, last1_q;
    logic           seq0_err_q, seq1_err_q, fmt_err_q;

    logic is_src0, is_src1, dst_ok, fmt_bad, seq0_bad, seq1_bad, err_any;

    always_comb begin
        is_src0  = (l_src_q == ASZ'(SRC0_ADDR));
        is_src1  = (l_src_q == ASZ'(SRC1_ADDR));
        dst_ok   = (l_dst_q >= ASZ'(MIN_ADDR)) && (l_dst_q <= ASZ'(MAX_ADDR));
        fmt_bad  = !(is_src0 || is_src1) || !dst_ok || (l_red_q != calc_red_q);
        seq0_bad = is_src0 && seen0_q && (l_dat_q[3:0] != last0_q + 4'd1);
        seq1_bad = is_src1 && seen1_q && (l_dat_q[3:0] != last1_q + 4'd1);
        err_any  = seq0_err_q || seq1_err_q || fmt_err_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            snk_state_q <= SNK_WAIT;
            ack_q       <= 1'b0;
            l_src_q     <= '0;
            l_dst_q     <= '0;
            l_dat_q     <= '0;
            l_red_q     <= '0;
            calc_red_q  <= '0;
            seen0_q     <= 1'b0;
            seen1_q     <= 1'b0;
            last0_q     <= '0;
            last1_q     <= '0;
            seq0_err_q  <= 1'b0;
            seq1_err_q  <= 1'b0;
            fmt_err_q   <= 1'b0;
        end else begin
            case (snk_state_q)
                SNK_WAIT: if (i0_req_i && !ack_q) snk_state_q <= SNK_LATCH;
                SNK_LATCH: begin
                    l_src_q     <= i0_src_i;
                    l_dst_q     <= i0_dst_i;
                    l_dat_q     <= i0_dat_i;
                    l_red_q     <= i0_red_i;
                    snk_state_q <= SNK_CALC;
                end
                SNK_CALC: begin
                    calc_red_q  <= RSZ'(calc_redun(32'(l_src_q), 32'(l_dst_q), 32'(l_dat_q),
                                                   ASZ, DSZ, RSZ));
                    snk_state_q <= SNK_CHECK;
                end
                SNK_CHECK: begin
                    // Once any error is latched, further messages are only tracked, not judged.
                    if (!err_any) begin
                        if (fmt_bad) begin
                            fmt_err_q <= 1'b1;
                        end else begin
                            if (seq0_bad) seq0_err_q <= 1'b1;
                            if (seq1_bad) seq1_err_q <= 1'b1;
                        end
                    end
                    if (!fmt_bad && is_src0) begin
                        seen0_q <= 1'b1;
                        last0_q <= l_dat_q[3:0];
                    end
                    if (!fmt_bad && is_src1) begin
                        seen1_q <= 1'b1;
                        last1_q <= l_dat_q[3:0];
                    end
                    ack_q       <= 1'b1;
                    snk_state_q <= SNK_ACK;
                end
                SNK_ACK: begin
                    if (!i0_req_i) begin
                        ack_q       <= 1'b0;
                        snk_state_q <= SNK_WAIT;
                    end
                end
                default: snk_state_q <= SNK_WAIT;
            endcase
        end
    end

    assign i0_ack_o    = ack_q;
    assign dbg_leds_o  = {fmt_err_q, seq1_err_q, seq0_err_q, err_any};
    assign dbg_disp0_o = last0_q;
    assign dbg_disp1_o = last1_q;

endmodule

// File: tb/tb_io_2to1.sv
// Directed bench for io_2to1 with MIN=1, MAX=3, 8/8/4-bit address/data/redundancy fields.
module tb_io_2to1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] o0_src, o0_dst, o0_dat, o1_src, o1_dst, o1_dat;
    logic [3:0] o0_red, o1_red;
    logic       o0_req, o0_ack, o1_req, o1_ack;
    logic [7:0] i0_src, i0_dst, i0_dat;
    logic [3:0] i0_red;
    logic       i0_req, i0_ack;
    logic [3:0] leds, disp0, disp1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_2to1 #(
        .MIN_ADDR(1), .MAX_ADDR(3), .SRC0_ADDR(9), .SRC1_ADDR(10),
        .ASZ(8), .DSZ(8), .RSZ(4)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .o0_src_o(o0_src), .o0_dst_o(o0_dst), .o0_dat_o(o0_dat), .o0_red_o(o0_red),
        .o0_req_o(o0_req), .o0_ack_i(o0_ack),
        .o1_src_o(o1_src), .o1_dst_o(o1_dst), .o1_dat_o(o1_dat), .o1_red_o(o1_red),
        .o1_req_o(o1_req), .o1_ack_i(o1_ack),
        .i0_src_i(i0_src), .i0_dst_i(i0_dst), .i0_dat_i(i0_dat), .i0_red_i(i0_red),
        .i0_req_i(i0_req), .i0_ack_o(i0_ack),
        .dbg_leds_o(leds), .dbg_disp0_o(disp0), .dbg_disp1_o(disp1)
    );

    function automatic logic [3:0] mred(input logic [7:0] s, input logic [7:0] d,
                                        input logic [7:0] t);
        return s[3:0] ^ s[7:4] ^ d[3:0] ^ d[7:4] ^ t[3:0] ^ t[7:4];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return o0_req;
            1:       return o1_req;
            default: return i0_ack;
        endcase
    endfunction

    task automatic wait_lvl(input int w, input logic lvl, input string tag);
        int n = 0;
        while (sig(w) !== lvl && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sig(w)), 32'(lvl));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_i0(input logic [7:0] s, input logic [7:0] d, input logic [7:0] t,
                           input logic [3:0] flip);
        i0_src = s;
        i0_dst = d;
        i0_dat = t;
        i0_red = mred(s, d, t) ^ flip;
        i0_req = 1'b1;
        wait_lvl(2, 1'b1, "i0_ack_up");
        i0_req = 1'b0;
        wait_lvl(2, 1'b0, "i0_ack_down");
    endtask

    logic [3:0] cnt0, cnt1;
    logic       first_fwd;

    // Moves one message from source k into the sink and checks the source data against the model.
    task automatic fwd(input int k);
        int n;
        wait_lvl(k, 1'b1, "fwd_req_up");
        if (k == 0) begin
            chk("fwd_o0_dat", 32'(o0_dat), 32'(cnt0));
            chk("fwd_o0_red", 32'(o0_red), 32'(mred(8'd9, o0_dst, o0_dat)));
            i0_src = o0_src; i0_dst = o0_dst; i0_dat = o0_dat; i0_red = o0_red;
        end else begin
            chk("fwd_o1_dat", 32'(o1_dat), 32'(cnt1));
            chk("fwd_o1_red", 32'(o1_red), 32'(mred(8'd10, o1_dst, o1_dat)));
            i0_src = o1_src; i0_dst = o1_dst; i0_dat = o1_dat; i0_red = o1_red;
        end
        i0_req = 1'b1;
        n = 0;
        while (i0_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (first_fwd) begin
            chk("sink_latency", 32'(n), 32'd4);
            first_fwd = 1'b0;
        end else begin
            chk("fwd_ack_up", 32'(i0_ack), 32'd1);
        end
        if (k == 0) o0_ack = 1'b1; else o1_ack = 1'b1;
        i0_req = 1'b0;
        wait_lvl(k, 1'b0, "fwd_req_down");
        if (k == 0) o0_ack = 1'b0; else o1_ack = 1'b0;
        wait_lvl(2, 1'b0, "fwd_ack_down");
        if (k == 0) begin
            chk("disp0_track", 32'(disp0), 32'(cnt0));
            cnt0 = cnt0 + 4'd1;
        end else begin
            chk("disp1_track", 32'(disp1), 32'(cnt1));
            cnt1 = cnt1 + 4'd1;
        end
    endtask

    logic [7:0] t1_dst [4];
    int         n5;

    initial begin
        t1_dst = '{8'd2, 8'd3, 8'd1, 8'd2};
        reset  = 1'b0;
        o0_ack = 1'b0;
        o1_ack = 1'b0;
        i0_src = '0; i0_dst = '0; i0_dat = '0; i0_red = '0; i0_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_o0_req", 32'(o0_req), 32'd0);
        chk("rst_o1_req", 32'(o1_req), 32'd0);
        chk("rst_i0_ack", 32'(i0_ack), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_disp0", 32'(disp0), 32'd0);
        chk("rst_disp1", 32'(disp1), 32'd0);
        chk("rst_o0_dst", 32'(o0_dst), 32'd1);
        chk("rst_o0_src", 32'(o0_src), 32'd9);
        chk("rst_o1_src", 32'(o1_src), 32'd10);
        reset = 1'b1;

        // Only o0 is acked: dst walks 2,3,1,2 with data 0..3
        for (int i = 0; i < 4; i++) begin
            wait_lvl(0, 1'b1, "t1_req_up");
            chk("t1_o0_dst", 32'(o0_dst), 32'(t1_dst[i]));
            chk("t1_o0_dat", 32'(o0_dat), 32'(i));
            chk("t1_o0_red", 32'(o0_red), 32'(mred(8'd9, t1_dst[i], 8'(i))));
            o0_ack = 1'b1;
            wait_lvl(0, 1'b0, "t1_req_down");
            o0_ack = 1'b0;
        end
        chk("t1_o1_held", 32'(o1_req), 32'd1);
        chk("t1_o1_dst", 32'(o1_dst), 32'd2);
        chk("t1_o1_dat", 32'(o1_dat), 32'd0);

        // Ack held high on o1 keeps it idle; next req comes 4 cycles after ack drops
        o1_ack = 1'b1;
        wait_lvl(1, 1'b0, "t5_req_down");
        repeat (10) @(negedge clk);
        chk("t5_no_req", 32'(o1_req), 32'd0);
        o1_ack = 1'b0;
        n5 = 0;
        while (o1_req !== 1'b1 && n5 < 50) begin
            @(negedge clk);
            n5++;
        end
        chk("t5_rereq_lat", 32'(n5), 32'd4);
        chk("t5_o1_dst", 32'(o1_dst), 32'd3);
        chk("t5_o1_dat", 32'(o1_dat), 32'd1);

        // Loopback of 40 alternating messages, including the 15->0 wrap
        cnt0      = 4'd4;
        cnt1      = 4'd1;
        first_fwd = 1'b1;
        for (int i = 0; i < 40; i++) fwd(i % 2);
        chk("t2_leds", 32'(leds), 32'd0);

        // Sequence error on src0
        pulse_reset();
        send_i0(8'd9, 8'd1, 8'd4, 4'd0);
        chk("t3_leds_a", 32'(leds), 32'd0);
        chk("t3_disp0_a", 32'(disp0), 32'd4);
        send_i0(8'd9, 8'd1, 8'd6, 4'd0);
        chk("t3_leds_b", 32'(leds), 32'b0011);
        chk("t3_disp0_b", 32'(disp0), 32'd6);
        send_i0(8'd9, 8'd1, 8'd7, 4'd0);
        chk("t3_leds_c", 32'(leds), 32'b0011);
        chk("t3_disp0_c", 32'(disp0), 32'd7);

        // Reset while the sink holds ack high
        i0_src = 8'd9; i0_dst = 8'd1; i0_dat = 8'd8; i0_red = mred(8'd9, 8'd1, 8'd8);
        i0_req = 1'b1;
        wait_lvl(2, 1'b1, "t6_ack_up");
        reset  = 1'b0;
        i0_req = 1'b0;
        @(negedge clk);
        chk("t6_ack", 32'(i0_ack), 32'd0);
        chk("t6_leds", 32'(leds), 32'd0);
        chk("t6_disp0", 32'(disp0), 32'd0);
        chk("t6_o0_req", 32'(o0_req), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send_i0(8'd9, 8'd1, 8'd9, 4'd0);
        chk("t6_seen_clr", 32'(leds), 32'd0);
        chk("t6_disp0_b", 32'(disp0), 32'd9);

        // Format errors: bad src, then bad dst, then corrupted redundancy
        send_i0(8'd5, 8'd1, 8'd10, 4'd0);
        chk("t4_src_leds", 32'(leds), 32'b1001);
        chk("t4_src_disp0", 32'(disp0), 32'd9);
        chk("t4_src_disp1", 32'(disp1), 32'd0);
        send_i0(8'd9, 8'd1, 8'd10, 4'd0);
        chk("t4_sticky", 32'(leds), 32'b1001);
        chk("t4_track", 32'(disp0), 32'd10);
        pulse_reset();
        send_i0(8'd10, 8'd4, 8'd3, 4'd0);
        chk("t4_dst_leds", 32'(leds), 32'b1001);
        chk("t4_dst_disp1", 32'(disp1), 32'd0);
        pulse_reset();
        send_i0(8'd10, 8'd2, 8'd3, 4'd1);
        chk("t4_red_leds", 32'(leds), 32'b1001);
        chk("t4_red_disp1", 32'(disp1), 32'd0);
        send_i0(8'd10, 8'd2, 8'd3, 4'd0);
        chk("t4_good_disp1", 32'(disp1), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
